// File: rtl/axi_sync_fifo_if.sv
// rtl/axi_sync_fifo_if.sv - upstream/downstream stream handshake bundle for axi_sync_fifo
interface axi_sync_fifo_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  vld_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rdy_in;
   logic                  vld_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rdy_out;

   // FIFO view: accepts the upstream stream, sources the downstream stream
   modport slave (
      input  vld_in,
      input  data_in,
      output rdy_in,
      output vld_out,
      output data_out,
      input  rdy_out
   );

   // Environment view: drives upstream beats, consumes the head entry
   modport master (
      output vld_in,
      output data_in,
      input  rdy_in,
      input  vld_out,
      input  data_out,
      output rdy_out
   );
endinterface

// File: rtl/axi_sync_fifo.sv
// rtl/axi_sync_fifo.sv - first-word-fall-through synchronous FIFO; optional peak watermark under AXI_SYNC_FIFO_WATERMARK_EN
module axi_sync_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   localparam int LW        = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   axi_sync_fifo_if.slave  fifo_if,
   output logic [LW-1:0]   level,
   output logic            almost_full,
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
   output logic            almost_empty,
   output logic [LW-1:0]   peak_level,
   input  logic            peak_clr
`else
   output logic            almost_empty
`endif
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L     = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L     = LW'(AE_THRESH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   // Flag values for an empty FIFO, used while reset is held
   localparam logic AF_AT_EMPTY = (AF_THRESH <= 0);
   localparam logic AE_AT_EMPTY = 1'b1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          af_q,     af_d;
   logic          ae_q,     ae_d;

   logic push;
   logic pop;

   // Handshake outputs depend only on registered occupancy, so there is no
   // combinational path between the two sides of the FIFO
   always_comb begin
      fifo_if.rdy_in   = (level_q < DEPTH_L);
      fifo_if.vld_out  = (level_q != '0);
      fifo_if.data_out = mem_q[rd_ptr_q];
   end

   assign push = fifo_if.vld_in  && fifo_if.rdy_in;
   assign pop  = fifo_if.vld_out && fifo_if.rdy_out;

   // Next-state pointers and occupancy; flush overrides any push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Threshold flags follow the post-edge occupancy so they change with level
   always_comb begin
      af_d = (level_d >= AF_L);
      ae_d = (level_d <= AE_L);
   end

   // Pointer, occupancy and flag state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         af_q     <= AF_AT_EMPTY;
         ae_q     <= AE_AT_EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
      end
   end

   // Payload storage is intentionally not reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= fifo_if.data_in;
      end
   end

   assign level        = level_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

`ifdef AXI_SYNC_FIFO_WATERMARK_EN
   logic [LW-1:0] peak_q, peak_d;

   // Peak tracks the running maximum; flush or clear restarts it from the new level
   always_comb begin
      peak_d = peak_q;
      if (flush || peak_clr) begin
         peak_d = level_d;
      end else if (level_d > peak_q) begin
         peak_d = level_d;
      end
   end

   // Watermark register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_axi_sync_fifo.sv
// tb/tb_axi_sync_fifo.sv - directed self-checking bench for axi_sync_fifo (DEPTH=5)
module tb_axi_sync_fifo;
   localparam int DW = 8;
   localparam int DP = 5;
   localparam int LW = $clog2(DP + 1);

   logic          clk;
   logic          rst;
   logic          flush;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          almost_empty;
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
   logic [LW-1:0] peak_level;
   logic          peak_clr;
`endif

   int total = 0;
   int bad   = 0;

   axi_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

   axi_sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP),
      .AF_THRESH  (4),
      .AE_THRESH  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .fifo_if      (bus.slave),
      .level        (level),
      .almost_full  (almost_full),
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      .almost_empty (almost_empty),
      .peak_level   (peak_level),
      .peak_clr     (peak_clr)
`else
      .almost_empty (almost_empty)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      flush        = 1'b0;
      bus.vld_in   = 1'b0;
      bus.data_in  = '0;
      bus.rdy_out  = 1'b0;
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      peak_clr     = 1'b0;
`endif
      step();
      step();

      chk("rst_level", 32'(level), 0);
      chk("rst_rdy_in", 32'(bus.rdy_in), 1);
      chk("rst_vld_out", 32'(bus.vld_out), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);

      rst = 1'b0;

      // Fill past capacity with the consumer stalled
      for (int i = 0; i < 7; i++) begin
         bus.vld_in  = 1'b1;
         bus.data_in = DW'(i);
         step();
         chk($sformatf("fill_level_%0d", i), 32'(level), (i < 5) ? i + 1 : 5);
         if (i == 0) begin
            chk("first_vld_out", 32'(bus.vld_out), 1);
            chk("first_data", 32'(bus.data_out), 0);
         end
      end
      bus.vld_in = 1'b0;
      chk("full_rdy_in", 32'(bus.rdy_in), 0);
      chk("full_af", 32'(almost_full), 1);
      chk("full_ae", 32'(almost_empty), 0);
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      chk("full_peak", 32'(peak_level), 5);
`endif

      // Drain in order
      bus.rdy_out = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain_vld_%0d", i), 32'(bus.vld_out), 1);
         chk($sformatf("drain_data_%0d", i), 32'(bus.data_out), i);
         step();
         chk($sformatf("drain_level_%0d", i), 32'(level), 4 - i);
         chk($sformatf("drain_rdy_in_%0d", i), 32'(bus.rdy_in), 1);
         if (i == 0) chk("af_at_4", 32'(almost_full), 1);
         if (i == 1) chk("af_at_3", 32'(almost_full), 0);
         if (i == 2) chk("ae_at_2", 32'(almost_empty), 0);
         if (i == 3) chk("ae_at_1", 32'(almost_empty), 1);
      end
      chk("drained_vld_out", 32'(bus.vld_out), 0);

      // Pop request while empty must not underflow
      step();
      chk("empty_no_underflow", 32'(level), 0);

      // Single beat through an empty FIFO
      bus.vld_in  = 1'b1;
      bus.data_in = 8'hA5;
      step();
      bus.vld_in = 1'b0;
      chk("a5_vld_out", 32'(bus.vld_out), 1);
      chk("a5_data", 32'(bus.data_out), 32'hA5);
      chk("a5_level", 32'(level), 1);
      step();
      chk("a5_popped_level", 32'(level), 0);
      chk("a5_popped_vld", 32'(bus.vld_out), 0);

      // One beat of prefill, then sustained push and pop
      bus.rdy_out = 1'b0;
      bus.vld_in  = 1'b1;
      bus.data_in = 8'h40;
      step();
      bus.rdy_out = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         bus.data_in = DW'(8'h40 + k);
         chk($sformatf("stream_data_%0d", k), 32'(bus.data_out), 32'h40 + k - 1);
         step();
         chk($sformatf("stream_level_%0d", k), 32'(level), 1);
      end
      bus.vld_in = 1'b0;
      chk("stream_last", 32'(bus.data_out), 32'h54);
      step();
      chk("stream_end_level", 32'(level), 0);

      // Flush with a simultaneous push
      bus.rdy_out = 1'b0;
      bus.vld_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.data_in = DW'(8'h80 + i);
         step();
      end
      chk("preflush_level", 32'(level), 3);
      flush       = 1'b1;
      bus.data_in = 8'h99;
      step();
      flush      = 1'b0;
      bus.vld_in = 1'b0;
      chk("flush_level", 32'(level), 0);
      chk("flush_vld_out", 32'(bus.vld_out), 0);
      chk("flush_ae", 32'(almost_empty), 1);
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      chk("flush_peak", 32'(peak_level), 0);
`endif
      bus.vld_in  = 1'b1;
      bus.data_in = 8'h77;
      step();
      bus.vld_in = 1'b0;
      chk("postflush_data", 32'(bus.data_out), 32'h77);
      chk("postflush_level", 32'(level), 1);
      bus.rdy_out = 1'b1;
      step();
      bus.rdy_out = 1'b0;
      chk("postflush_drained", 32'(level), 0);

      // Asynchronous reset between edges at level 4
      bus.vld_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.data_in = DW'(8'hC0 + i);
         step();
      end
      bus.vld_in = 1'b0;
      chk("prerst_level", 32'(level), 4);
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      chk("prerst_peak", 32'(peak_level), 4);
`endif
      #2;
      rst = 1'b1;
      #1;
      chk("arst_level", 32'(level), 0);
      chk("arst_vld_out", 32'(bus.vld_out), 0);
      chk("arst_rdy_in", 32'(bus.rdy_in), 1);
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      chk("arst_peak", 32'(peak_level), 0);
`endif
      #1;
      rst = 1'b0;

      // First push after reset release
      bus.vld_in  = 1'b1;
      bus.data_in = 8'h11;
      step();
      bus.data_in = 8'h22;
      step();
      bus.vld_in = 1'b0;
      chk("postrst_level", 32'(level), 2);
      chk("postrst_data", 32'(bus.data_out), 32'h11);
`ifdef AXI_SYNC_FIFO_WATERMARK_EN
      chk("peak_two", 32'(peak_level), 2);
      bus.rdy_out = 1'b1;
      peak_clr    = 1'b1;
      step();
      bus.rdy_out = 1'b0;
      peak_clr    = 1'b0;
      chk("peak_clr_loads_level", 32'(peak_level), 1);
      bus.vld_in  = 1'b1;
      bus.data_in = 8'h33;
      step();
      bus.vld_in = 1'b0;
      chk("peak_regrow", 32'(peak_level), 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_sync_fifo.md
AXI_SYNC_FIFO -- requirements
Module: axi_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 64, payload width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, 4, entry count; SHALL be >= 2; power of two not required.
REQ-003 Parameter AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH; SHALL be 1..DEPTH.
REQ-004 Parameter AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH; SHALL be 0..DEPTH-1.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  synchronous discard of all contents.
REQ-009 vld_in  input  1  upstream data valid.
REQ-010 data_in  input  DATA_WIDTH  upstream payload.
REQ-011 rdy_in  output  1  FIFO can accept a beat.
REQ-012 vld_out  output  1  head entry valid.
REQ-013 data_out  output  DATA_WIDTH  head entry payload.
REQ-014 rdy_out  input  1  downstream accepts head.
REQ-015 level  output  $clog2(DEPTH+1)  current occupancy 0..DEPTH.
REQ-016 almost_full, almost_empty  output  1 each  threshold flags per REQ-003/004.

Function
REQ-017 Push = vld_in && rdy_in at rising clk edge; pop = vld_out && rdy_out at rising clk edge.
REQ-018 rdy_in SHALL equal (level < DEPTH); no combinational path from rdy_out to rdy_in.
REQ-019 vld_out SHALL equal (level != 0); no combinational path from vld_in to vld_out.
REQ-020 First-word-fall-through: data_out SHALL show the oldest stored entry whenever vld_out is high, with no read latency.
REQ-021 A beat pushed at edge N SHALL be visible on vld_out/data_out after edge N (empty-to-valid latency 1 cycle); no bypass when empty.
REQ-022 Beats SHALL leave in push order; no loss, duplication or reordering.
REQ-023 Push only: level +1; pop only: level -1; push and pop same edge: level unchanged, both pointers advance.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0, valid for non-power-of-two DEPTH.
REQ-025 Full (level == DEPTH): rdy_in low, vld_in ignored, stored data unchanged; a pop reopens rdy_in the next cycle.
REQ-026 Empty (level == 0): vld_out low, rdy_out ignored, level never underflows.
REQ-027 Sustained push+pop with 1 <= level < DEPTH SHALL achieve one beat per cycle.
REQ-028 flush high at an edge: level, both pointers cleared; push and pop on that edge are discarded; flush has priority.
REQ-029 almost_full, almost_empty, level SHALL be registered-state functions, updated on the same edge as level.
REQ-030 Storage contents SHALL not be reset; data_out is don't-care while vld_out is low.

Reset
REQ-031 While rst high: level=0, pointers=0, rdy_in=1, vld_out=0, almost_empty=1, almost_full=0 (for AF_THRESH >= 1).
REQ-032 rst asserted mid-operation SHALL discard all contents immediately, without waiting for a clock edge.
REQ-033 First push SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-034 Macro AXI_SYNC_FIFO_WATERMARK_EN defined: add output peak_level ($clog2(DEPTH+1) bits) and input peak_clr (1 bit).
REQ-035 With the macro, peak_level SHALL hold the maximum level since the last reset/peak_clr/flush; it updates on the same edge as level; peak_clr at an edge loads the post-edge level.
REQ-036 Without the macro, peak_level and peak_clr SHALL not exist and no watermark logic SHALL be present.

Verification
REQ-037 DEPTH=5, push 7 beats with rdy_out=0 -> 5 accepted, rdy_in low after the 5th, level=5, almost_full=1; drain gives beats 0..4 in order.
REQ-038 DEPTH=5, continuous push+pop for 20 cycles after one beat of prefill -> one beat per cycle, level constant at 1, pointers wrap 4->0 cleanly.
REQ-039 Empty FIFO, push 0xA5 at edge N, rdy_out=1 -> vld_out=1, data_out=0xA5 in cycle N+1, popped at edge N+1, level back to 0.
REQ-040 level=3, flush and push asserted at the same edge -> level=0, vld_out=0, pushed beat lost.
REQ-041 level=4, async rst pulse between edges -> vld_out=0, level=0 before the next edge; WATERMARK_EN: peak_level=4 before reset, 0 after.
